// File: rtl/witf_mt_pkg.sv
// Shared sizing defaults and helpers for the writeback-instruction tracking FIFO.
// Optional WAW checking is enabled by defining WITF_WAW_CHK_EN.
package witf_mt_pkg;

    localparam int unsigned WITF_DEPTH = 4;
    localparam int unsigned WITF_RAW   = 5;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/witf_mt_if.sv
// Dispatch / writeback / status bundle between ID (master) and the tracking FIFO (slave).
interface witf_mt_if
    import witf_mt_pkg::*;
#(
    parameter int unsigned RAW = WITF_RAW,
    parameter int unsigned CW  = cnt_width(WITF_DEPTH)
);
    logic           disp_en;
    logic           disp_rs1en;
    logic [RAW-1:0] disp_rs1;
    logic           disp_rs2en;
    logic [RAW-1:0] disp_rs2;
    logic           disp_rdwen;
    logic [RAW-1:0] disp_rd;
    logic           disp_ok;
    logic           hazard;
    logic           witf_full;
    logic           witf_empty;
    logic [CW-1:0]  witf_cnt;
    logic           wb_en;
    logic           ret_rdwen;
    logic [RAW-1:0] ret_rd;
    logic           flush_witf;

    modport master (
        output disp_en, disp_rs1en, disp_rs1, disp_rs2en, disp_rs2,
               disp_rdwen, disp_rd, wb_en, flush_witf,
        input  disp_ok, hazard, witf_full, witf_empty, witf_cnt, ret_rdwen, ret_rd
    );

    modport slave (
        input  disp_en, disp_rs1en, disp_rs1, disp_rs2en, disp_rs2,
               disp_rdwen, disp_rd, wb_en, flush_witf,
        output disp_ok, hazard, witf_full, witf_empty, witf_cnt, ret_rdwen, ret_rd
    );
endinterface

// File: rtl/witf_mt_entry.sv
// One tracking slot: valid/rd/rdwen storage plus source (and optionally rd) compare.
// With WITF_WAW_CHK_EN defined the slot also matches the dispatching rd.
module witf_mt_entry #(
    parameter int unsigned RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           set,
    input  logic           pop,
    input  logic           rd_in,
    input  logic [RAW-1:0] rd_idx,
    input  logic           rs1en,
    input  logic [RAW-1:0] rs1,
    input  logic           rs2en,
    input  logic [RAW-1:0] rs2,
`ifdef WITF_WAW_CHK_EN
    input  logic           drdwen,
    input  logic [RAW-1:0] drd,
`endif
    output logic           hit,
    output logic           rdwen,
    output logic [RAW-1:0] rd
);

    logic valid;
    logic live;

    // set and pop never target the same slot in one cycle (wptr==rptr only when empty or full)
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= 1'b0;
        end else if (set) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            rd    <= rd_idx;
            rdwen <= rd_in;
        end
    end

    // x0 is never a real producer, so it never blocks a consumer
    always_comb begin
        live = valid && rdwen && (rd != '0);
        hit  = live && ((rs1en && (rd == rs1)) || (rs2en && (rd == rs2)));
`ifdef WITF_WAW_CHK_EN
        if (live && drdwen && (drd != '0) && (drd == rd)) begin
            hit = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/witf_mt.sv
// In-order tracker of in-flight long-latency rd writers; flags dispatch hazards for ID.
// Define WITF_WAW_CHK_EN to also flag write-after-write against tracked rds.
module witf_mt
    import witf_mt_pkg::*;
#(
    parameter int unsigned DEPTH = WITF_DEPTH,
    parameter int unsigned RAW   = WITF_RAW
) (
    input  logic clk,
    input  logic rst,
    witf_mt_if.slave bus
);

    localparam int unsigned   CW   = cnt_width(DEPTH);
    localparam int unsigned   PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           wflag;
    logic           rflag;
    logic [CW-1:0]  cnt;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] ent_rdwen;
    logic [RAW-1:0] ent_rd [DEPTH];
    logic           full;
    logic           empty;
    logic           hazard;
    logic           push;
    logic           pop;

    // Status and handshake decode from registered pointers only
    always_comb begin
        empty  = (wptr == rptr) && (wflag == rflag);
        full   = (wptr == rptr) && (wflag != rflag);
        hazard = |hit;
        push   = bus.disp_en && !hazard && !full && !bus.flush_witf;
        pop    = bus.wb_en && !empty && !bus.flush_witf;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        witf_mt_entry #(.RAW(RAW)) u_ent (
            .clk    (clk),
            .rst    (rst),
            .clr    (bus.flush_witf),
            .set    (push && (wptr == PW'(i))),
            .pop    (pop && (rptr == PW'(i))),
            .rd_in  (bus.disp_rdwen),
            .rd_idx (bus.disp_rd),
            .rs1en  (bus.disp_rs1en),
            .rs1    (bus.disp_rs1),
            .rs2en  (bus.disp_rs2en),
            .rs2    (bus.disp_rs2),
`ifdef WITF_WAW_CHK_EN
            .drdwen (bus.disp_rdwen),
            .drd    (bus.disp_rd),
`endif
            .hit    (hit[i]),
            .rdwen  (ent_rdwen[i]),
            .rd     (ent_rd[i])
        );
    end

    // Pointers wrap at DEPTH-1 (not a power of two in general); wrap flags split full from empty
    always_ff @(posedge clk) begin
        if (rst || bus.flush_witf) begin
            wptr  <= '0;
            rptr  <= '0;
            wflag <= 1'b0;
            rflag <= 1'b0;
            cnt   <= '0;
        end else begin
            if (push) begin
                if (wptr == LAST) begin
                    wptr  <= '0;
                    wflag <= ~wflag;
                end else begin
                    wptr <= wptr + PW'(1);
                end
            end
            if (pop) begin
                if (rptr == LAST) begin
                    rptr  <= '0;
                    rflag <= ~rflag;
                end else begin
                    rptr <= rptr + PW'(1);
                end
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.disp_ok    = push;
    assign bus.hazard     = hazard;
    assign bus.witf_full  = full;
    assign bus.witf_empty = empty;
    assign bus.witf_cnt   = cnt;
    assign bus.ret_rdwen  = !empty && ent_rdwen[rptr];
    assign bus.ret_rd     = empty ? '0 : ent_rd[rptr];

endmodule

// File: tb/tb_witf_mt.sv
// Bench for witf_mt: DEPTH=4 and DEPTH=3 instances share stimulus; a queue model per instance.
module tb_witf_mt;

    typedef logic [5:0] ent_t;  // {rdwen, rd}

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       disp_en, disp_rs1en, disp_rs2en, disp_rdwen, wb_en, flush;
    logic [4:0] disp_rs1, disp_rs2, disp_rd;

    int tests = 0;
    int fails = 0;

    ent_t q4[$];
    ent_t q3[$];

    always #5 clk = ~clk;

    witf_mt_if #(.RAW(5), .CW(3)) b4 ();
    witf_mt_if #(.RAW(5), .CW(2)) b3 ();

    assign b4.disp_en = disp_en;       assign b3.disp_en = disp_en;
    assign b4.disp_rs1en = disp_rs1en; assign b3.disp_rs1en = disp_rs1en;
    assign b4.disp_rs1 = disp_rs1;     assign b3.disp_rs1 = disp_rs1;
    assign b4.disp_rs2en = disp_rs2en; assign b3.disp_rs2en = disp_rs2en;
    assign b4.disp_rs2 = disp_rs2;     assign b3.disp_rs2 = disp_rs2;
    assign b4.disp_rdwen = disp_rdwen; assign b3.disp_rdwen = disp_rdwen;
    assign b4.disp_rd = disp_rd;       assign b3.disp_rd = disp_rd;
    assign b4.wb_en = wb_en;           assign b3.wb_en = wb_en;
    assign b4.flush_witf = flush;      assign b3.flush_witf = flush;

    witf_mt #(.DEPTH(4), .RAW(5)) u4 (.clk(clk), .rst(rst), .bus(b4));
    witf_mt #(.DEPTH(3), .RAW(5)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A tracked instruction blocks dispatch if it will write a register the new one reads
    function automatic logic exp_haz(input ent_t q[$]);
        logic h = 1'b0;
        foreach (q[i]) begin
            if (q[i][5] && q[i][4:0] != 5'd0) begin
                if (disp_rs1en && q[i][4:0] == disp_rs1) h = 1'b1;
                if (disp_rs2en && q[i][4:0] == disp_rs2) h = 1'b1;
`ifdef WITF_WAW_CHK_EN
                if (disp_rdwen && q[i][4:0] == disp_rd) h = 1'b1;
`endif
            end
        end
        return h;
    endfunction

    function automatic logic exp_ok(input ent_t q[$], input int depth);
        return disp_en && !exp_haz(q) && (q.size() < depth) && !flush;
    endfunction

    task automatic cmp(input string tag, input ent_t q[$], input int depth,
                       input logic hz, input logic ok, input logic fu, input logic em,
                       input int cnt, input logic rw, input logic [4:0] rd);
        ent_t head = (q.size() > 0) ? q[0] : 6'd0;
        chk({tag, ".hazard"}, 32'(hz), 32'(exp_haz(q)));
        chk({tag, ".disp_ok"}, 32'(ok), 32'(exp_ok(q, depth)));
        chk({tag, ".full"}, 32'(fu), 32'(q.size() == depth));
        chk({tag, ".empty"}, 32'(em), 32'(q.size() == 0));
        chk({tag, ".cnt"}, cnt, q.size());
        chk({tag, ".ret_rdwen"}, 32'(rw), 32'(head[5]));
        chk({tag, ".ret_rd"}, 32'(rd), 32'(head[4:0]));
    endtask

    // Model update at the active edge; inputs are stable here
    always @(posedge clk) begin
        logic ok4, ok3;
        ok4 = exp_ok(q4, 4);
        ok3 = exp_ok(q3, 3);
        if (rst || flush) begin
            q4.delete();
            q3.delete();
        end else begin
            if (wb_en && q4.size() > 0) void'(q4.pop_front());
            if (ok4) q4.push_back({disp_rdwen, disp_rd});
            if (wb_en && q3.size() > 0) void'(q3.pop_front());
            if (ok3) q3.push_back({disp_rdwen, disp_rd});
        end
    end

    // Single compare process on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            cmp("d4", q4, 4, b4.hazard, b4.disp_ok, b4.witf_full, b4.witf_empty,
                32'(b4.witf_cnt), b4.ret_rdwen, b4.ret_rd);
            cmp("d3", q3, 3, b3.hazard, b3.disp_ok, b3.witf_full, b3.witf_empty,
                32'(b3.witf_cnt), b3.ret_rdwen, b3.ret_rd);
        end
    end

    task automatic drive(input logic en, input logic r1e, input logic [4:0] r1,
                         input logic r2e, input logic [4:0] r2, input logic wen,
                         input logic [4:0] rd, input logic wb, input logic fl);
        disp_en = en; disp_rs1en = r1e; disp_rs1 = r1; disp_rs2en = r2e; disp_rs2 = r2;
        disp_rdwen = wen; disp_rd = rd; wb_en = wb; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic wen, input logic [4:0] rd);
        drive(1, 0, 0, 0, 0, wen, rd, 0, 0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset.empty", 32'(b4.witf_empty), 1);
        chk("reset.cnt", 32'(b4.witf_cnt), 0);
        chk("reset.ret_rd", 32'(b4.ret_rd), 0);

        // RAW on rd=5 blocks until its writeback has been seen
        next_cycle(); push(1, 5);
        @(negedge clk); chk("t1.push_ok", 32'(b4.disp_ok), 1);
        next_cycle(); drive(1, 1, 5, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("t1.hazard", 32'(b4.hazard), 1);
        chk("t1.blocked", 32'(b4.disp_ok), 0);
        next_cycle(); drive(0, 1, 5, 0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("t1.hazard_pop_cycle", 32'(b4.hazard), 1);
        next_cycle(); drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t1.hazard_clear", 32'(b4.hazard), 0);

        // x0 and non-writing entries never match
        next_cycle(); push(1, 0);
        next_cycle(); drive(1, 1, 0, 0, 0, 0, 7, 0, 0);
        @(negedge clk); chk("t2.x0_hazard", 32'(b4.hazard), 0);
        next_cycle(); drive(0, 0, 0, 1, 7, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2.nowr_hazard", 32'(b4.hazard), 0);
        chk("t2.cnt", 32'(b4.witf_cnt), 2);

        // flush wins over same-cycle push and pop
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 3, 1, 1);
        @(negedge clk); chk("t5.flush_no_push", 32'(b4.disp_ok), 0);
        next_cycle(); idle();
        @(negedge clk);
        chk("t5.empty", 32'(b4.witf_empty), 1);
        chk("t5.cnt", 32'(b4.witf_cnt), 0);

        // fill DEPTH=4, then pop+push while full: push refused
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); push(1, 5'(i));
        end
        next_cycle(); idle();
        @(negedge clk);
        chk("t3.full", 32'(b4.witf_full), 1);
        chk("t3.cnt", 32'(b4.witf_cnt), 4);
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 6, 1, 0);
        @(negedge clk); chk("t3.full_refuse", 32'(b4.disp_ok), 0);
        next_cycle(); idle();
        @(negedge clk);
        chk("t3.cnt_after", 32'(b4.witf_cnt), 3);
        chk("t3.ret_rd", 32'(b4.ret_rd), 2);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // WAW against a tracked rd=9
        next_cycle(); push(1, 9);
        next_cycle(); push(1, 9);
        @(negedge clk);
`ifdef WITF_WAW_CHK_EN
        chk("t6.waw", 32'(b4.hazard), 1);
`else
        chk("t6.waw", 32'(b4.hazard), 0);
`endif
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // wrap on DEPTH=3: steady one-deep push/pop, retire order follows push order
        next_cycle(); push(1, 20);
        for (int i = 0; i < 6; i++) begin
            next_cycle(); drive(1, 0, 0, 0, 0, 1, 5'(21 + i), 1, 0);
            @(negedge clk);
            chk("t4.ret_rd", 32'(b3.ret_rd), 20 + i);
            chk("t4.cnt", 32'(b3.witf_cnt), 1);
        end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic; small register range to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 6, 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) < 4,
                  $urandom_range(0, 49) == 0);
        end
        next_cycle(); rst = 1'b0; idle();
        @(negedge clk);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
